// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory port arbiter and the MEM-stage load path.
//   SZ_*          access size encodings
//   arb_state_e   arbiter FSM states
//   dmem_req_t    one master's request bundle
//   size_byteena  size -> byte-lane enables (low lane = addressed byte)
//   misaligned    natural-alignment check used by the optional trap
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {
    ST_ARB       = 1'b0,
    ST_AUX_FORCE = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dmem_req_t;

  // Size 2'b11 is not a legal encoding; it is treated as a word.
  function automatic logic [3:0] size_byteena(input logic [1:0] size);
    case (size)
      SZ_BYTE: size_byteena = 4'b0001;
      SZ_HALF: size_byteena = 4'b0011;
      default: size_byteena = 4'b1111;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = addr_lo[0];
      default: misaligned = |addr_lo;
    endcase
  endfunction

endpackage

// File: rtl/dmem_load_ext.sv
// Load-data extension: picks byte/half/word from the low lanes of the memory
// read data and sign- or zero-extends it to 32 bits. Purely combinational so
// the MEM stage can reuse it.
//   size  in  2   SZ_BYTE/SZ_HALF/SZ_WORD (2'b11 = word)
//   sext  in  1   1 = sign-extend, 0 = zero-extend
//   data  in  32  raw memory data, addressed byte in [7:0]
//   ext   out 32  extended result
module dmem_load_ext
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        sext,
  input  logic [31:0] data,
  output logic [31:0] ext
);

  always_comb begin
    case (size)
      SZ_BYTE: ext = {{24{sext & data[7]}},  data[7:0]};
      SZ_HALF: ext = {{16{sext & data[15]}}, data[15:0]};
      default: ext = data;
    endcase
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Data-memory port arbiter: shares one single-port byte-addressed memory
// between the CPU MEM stage (primary) and an auxiliary master. One access per
// cycle; load data is registered (with extension) and returned the next cycle.
// The aux port is guaranteed progress: after STARVE_MAX consecutive wait
// cycles the next cycle belongs to aux unconditionally.
//
// Ports
//   clk, rst                     clock; synchronous active-high reset
//   cpu_req/we/size/sext/addr/wdata   CPU request (held until cpu_gnt)
//   cpu_gnt                      combinational accept
//   cpu_rvalid/cpu_rdata         load response, one cycle after grant
//   aux_*                        same set for the auxiliary master
//   dm_ena/w/r/byteena/addr/wdata  memory command (combinational)
//   dm_rdata                     memory read data, addressed byte in low lane
//   cpu_err/aux_err              misalignment pulse (trap build only, else 0)
//
// Build option: define MISALIGN_TRAP_EN to accept-but-drop misaligned
// half/word accesses and report them on <port>_err in the following cycle.
module dmem_port_arbiter
  import dmem_pkg::*;
#(
  parameter int STARVE_MAX = 8,
  parameter int AW         = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [1:0]  cpu_size,
  input  logic        cpu_sext,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_gnt,
  output logic        cpu_rvalid,
  output logic [31:0] cpu_rdata,
  output logic        cpu_err,
  input  logic        aux_req,
  input  logic        aux_we,
  input  logic [1:0]  aux_size,
  input  logic        aux_sext,
  input  logic [31:0] aux_addr,
  input  logic [31:0] aux_wdata,
  output logic        aux_gnt,
  output logic        aux_rvalid,
  output logic [31:0] aux_rdata,
  output logic        aux_err,
  output logic        dm_ena,
  output logic        dm_w,
  output logic        dm_r,
  output logic [3:0]  dm_byteena,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata
);

  localparam int NUM_PORTS = 2;   // [0] = cpu, [1] = aux
  localparam int CW        = $clog2(STARVE_MAX + 1);

  dmem_req_t [NUM_PORTS-1:0] req;
  dmem_req_t                 sel;
  logic [NUM_PORTS-1:0]      gnt;
  logic [NUM_PORTS-1:0]      rvalid_q;
  logic [31:0]               rdata_q;
  logic [31:0]               ld_ext;
  logic                      acc_ok;
  logic                      aux_wait;
  arb_state_e                state;
  logic [CW-1:0]             starve_cnt;

  assign req[0] = {cpu_we, cpu_size, cpu_sext, cpu_addr, cpu_wdata};
  assign req[1] = {aux_we, aux_size, aux_sext, aux_addr, aux_wdata};

  // Grants are combinational so the MEM stage can stall in the same cycle.
  // Nothing is granted during reset.
  always_comb begin
    gnt = '0;
    if (!rst) begin
      if (state == ST_ARB) begin
        gnt[0] = cpu_req;
        gnt[1] = aux_req & ~cpu_req;
      end else begin
        gnt[1] = aux_req;
      end
    end
  end

  assign cpu_gnt  = gnt[0];
  assign aux_gnt  = gnt[1];
  assign sel      = gnt[1] ? req[1] : req[0];
  assign aux_wait = aux_req & ~gnt[1];

`ifdef MISALIGN_TRAP_EN
  logic                 mis;
  logic [NUM_PORTS-1:0] err_q;

  // A trapped access still completes its handshake; it just never reaches memory.
  assign mis    = misaligned(sel.size, sel.addr[1:0]);
  assign acc_ok = (|gnt) & ~mis;

  always_ff @(posedge clk) begin
    if (rst) err_q <= '0;
    else     err_q <= gnt & {NUM_PORTS{mis}};
  end

  assign cpu_err = err_q[0] & ~rst;
  assign aux_err = err_q[1] & ~rst;
`else
  assign acc_ok  = |gnt;
  assign cpu_err = 1'b0;
  assign aux_err = 1'b0;
`endif

  assign dm_ena     = acc_ok;
  assign dm_w       = acc_ok & sel.we;
  assign dm_r       = acc_ok & ~sel.we;
  assign dm_byteena = acc_ok ? size_byteena(sel.size) : 4'b0000;
  assign dm_addr    = {sel.addr[31:AW], sel.addr[AW-1:0]};
  assign dm_wdata   = sel.wdata;

  dmem_load_ext u_ext (
    .size (sel.size),
    .sext (sel.sext),
    .data (dm_rdata),
    .ext  (ld_ext)
  );

  // Extended data is captured at the end of the granted cycle, so a store
  // issued in the next cycle cannot disturb it. The register is shared by
  // both ports; rvalid says who owns it.
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_q <= '0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= gnt & {NUM_PORTS{dm_r}};
      if (dm_r) rdata_q <= ld_ext;
    end
  end

  // A response due in the cycle reset is raised is dropped, not delivered late.
  assign cpu_rvalid = rvalid_q[0] & ~rst;
  assign aux_rvalid = rvalid_q[1] & ~rst;
  assign cpu_rdata  = rdata_q;
  assign aux_rdata  = rdata_q;

  // Starvation counter and FSM. starve_cnt holds the number of consecutive
  // aux wait cycles so far; the wait that brings it to STARVE_MAX arms the
  // forced grant for the following cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_ARB;
      starve_cnt <= '0;
    end else begin
      if (!aux_wait)                          starve_cnt <= '0;
      else if (starve_cnt != CW'(STARVE_MAX)) starve_cnt <= starve_cnt + CW'(1);

      case (state)
        ST_ARB:
          if (aux_wait && starve_cnt == CW'(STARVE_MAX - 1)) state <= ST_AUX_FORCE;
        ST_AUX_FORCE:
          if (gnt[1] || !aux_req) state <= ST_ARB;
        default: state <= ST_ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: a table of single loads, directed
// multi-cycle sequences (starvation, priority, reset, misalignment) and a
// randomized run against a transaction-level reference model.
module tb_dmem_port_arbiter;
  import dmem_pkg::*;

  localparam int SM = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b1;
  logic        cpu_req, cpu_we, cpu_sext, aux_req, aux_we, aux_sext;
  logic [1:0]  cpu_size, aux_size;
  logic [31:0] cpu_addr, cpu_wdata, aux_addr, aux_wdata;
  logic        cpu_gnt, cpu_rvalid, cpu_err, aux_gnt, aux_rvalid, aux_err;
  logic [31:0] cpu_rdata, aux_rdata;
  logic        dm_ena, dm_w, dm_r;
  logic [3:0]  dm_byteena;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;

  int total = 0;
  int bad   = 0;

  logic [7:0] mem     [0:255];
  logic [7:0] ref_mem [0:255];

  dmem_port_arbiter #(.STARVE_MAX(SM), .AW(11)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_size(cpu_size), .cpu_sext(cpu_sext),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt),
    .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
    .aux_req(aux_req), .aux_we(aux_we), .aux_size(aux_size), .aux_sext(aux_sext),
    .aux_addr(aux_addr), .aux_wdata(aux_wdata), .aux_gnt(aux_gnt),
    .aux_rvalid(aux_rvalid), .aux_rdata(aux_rdata), .aux_err(aux_err),
    .dm_ena(dm_ena), .dm_w(dm_w), .dm_r(dm_r), .dm_byteena(dm_byteena),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata)
  );

  always #5 clk = ~clk;

  // Byte-granular memory model, 256 bytes, wraps on the low address byte.
  assign dm_rdata = {mem[8'(dm_addr[7:0] + 8'd3)], mem[8'(dm_addr[7:0] + 8'd2)],
                     mem[8'(dm_addr[7:0] + 8'd1)], mem[dm_addr[7:0]]};

  always @(negedge clk) begin
    if (clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    end else if (dm_ena && dm_w) begin
      for (int k = 0; k < 4; k++)
        if (dm_byteena[k]) mem[8'(dm_addr[7:0] + 8'(k))] <= dm_wdata[8*k +: 8];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cpu_req = 0; cpu_we = 0; cpu_size = SZ_WORD; cpu_sext = 0; cpu_addr = 0; cpu_wdata = 0;
    aux_req = 0; aux_we = 0; aux_size = SZ_WORD; aux_sext = 0; aux_addr = 0; aux_wdata = 0;
  endtask

  task automatic drive(input logic port, input logic we, input logic [1:0] size,
                       input logic sext, input logic [31:0] addr, input logic [31:0] wdata);
    if (port) begin
      aux_req = 1; aux_we = we; aux_size = size; aux_sext = sext; aux_addr = addr; aux_wdata = wdata;
    end else begin
      cpu_req = 1; cpu_we = we; cpu_size = size; cpu_sext = sext; cpu_addr = addr; cpu_wdata = wdata;
    end
  endtask

  // Hold cpu and aux loads and note the cycle numbers of the first two aux grants.
  task automatic starve_run(input int limit, output int g1, output int g2, output int both);
    g1 = 0; g2 = 0; both = 0;
    drive(0, 0, SZ_WORD, 0, 32'h10, 0);
    drive(1, 0, SZ_WORD, 0, 32'h14, 0);
    for (int c = 1; c <= limit && g2 == 0; c++) begin
      #1;
      if (aux_gnt && cpu_gnt) both++;
      if (aux_gnt) begin
        if (g1 == 0) g1 = c;
        else         g2 = c;
      end
      tick();
    end
    idle();
  endtask

  // Reference load: assemble bytes from the model memory and extend arithmetically.
  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz,
                                           input logic sext);
    int     n;
    longint v;
    n = (sz == SZ_BYTE) ? 1 : (sz == SZ_HALF) ? 2 : 4;
    v = 0;
    for (int k = 0; k < n; k++) v = v + (longint'(ref_mem[8'(a[7:0] + 8'(k))]) << (8 * k));
    if (sext && n < 4 && ((v >> (8 * n - 1)) & 1) == 1) v = v - (longint'(1) << (8 * n));
    return 32'(v);
  endfunction

  typedef struct {
    string       nm;
    logic        port;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] pre;
    logic [3:0]  be;
    logic [31:0] exp;
  } vec_t;

  vec_t vt [8];

  initial begin
    int g1, g2, both;
    logic [31:0] rd_before;
    vt[0] = '{"lw_10",      0, SZ_WORD, 0, 32'h10, 32'h8899AABB, 4'b1111, 32'h8899AABB};
    vt[1] = '{"lb_sext_13", 0, SZ_BYTE, 1, 32'h13, 32'h80000000, 4'b0001, 32'hFFFFFF80};
    vt[2] = '{"lbu_13",     0, SZ_BYTE, 0, 32'h13, 32'h80000000, 4'b0001, 32'h00000080};
    vt[3] = '{"lh_sext_14", 0, SZ_HALF, 1, 32'h14, 32'h00007FFF, 4'b0011, 32'h00007FFF};
    vt[4] = '{"aux_lh_16",  1, SZ_HALF, 1, 32'h16, 32'h80010000, 4'b0011, 32'hFFFF8001};
    vt[5] = '{"aux_lhu_16", 1, SZ_HALF, 0, 32'h16, 32'h80010000, 4'b0011, 32'h00008001};
    vt[6] = '{"lb_sext_18", 0, SZ_BYTE, 1, 32'h18, 32'h0000007F, 4'b0001, 32'h0000007F};
    vt[7] = '{"aux_sz11_1c",1, 2'b11,   0, 32'h1C, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF};

    // Reset: requests present, a store pending, but nothing may reach memory.
    idle();
    drive(0, 1, SZ_WORD, 0, 32'h40, 32'hFFFFFFFF);
    drive(1, 0, SZ_WORD, 0, 32'h44, 0);
    tick(); tick();
    chk("rst_gnt", {30'd0, cpu_gnt, aux_gnt}, 32'd0);
    chk("rst_dm_ena", {31'd0, dm_ena}, 32'd0);
    idle();
    rst = 0; clr = 0;
    tick();
    chk("rst_rvalid", {30'd0, cpu_rvalid, aux_rvalid}, 32'd0);
    chk("rst_rdata", cpu_rdata, 32'd0);
    chk("rst_err", {30'd0, cpu_err, aux_err}, 32'd0);

    // Table of single loads, each preceded by a word store through the cpu port.
    foreach (vt[i]) begin
      drive(0, 1, SZ_WORD, 0, {vt[i].addr[31:2], 2'b00}, vt[i].pre);
      tick();
      idle();
      drive(vt[i].port, 0, vt[i].size, vt[i].sext, vt[i].addr, 0);
      #1;
      chk({vt[i].nm, "_gnt"}, {30'd0, aux_gnt, cpu_gnt}, vt[i].port ? 32'd2 : 32'd1);
      chk({vt[i].nm, "_be"}, {28'd0, dm_byteena}, {28'd0, vt[i].be});
      tick();
      idle();
      chk({vt[i].nm, "_rvalid"}, {30'd0, aux_rvalid, cpu_rvalid}, vt[i].port ? 32'd2 : 32'd1);
      chk({vt[i].nm, "_rdata"}, vt[i].port ? aux_rdata : cpu_rdata, vt[i].exp);
      tick();
      chk({vt[i].nm, "_rvalid_1cyc"}, {30'd0, aux_rvalid, cpu_rvalid}, 32'd0);
    end

    // aux half store into a zeroed word, then cpu word load; then priority.
    drive(0, 1, SZ_WORD, 0, 32'h20, 0);
    tick(); idle();
    drive(1, 1, SZ_HALF, 0, 32'h20, 32'hABCD1234);
    tick(); idle();
    drive(0, 0, SZ_WORD, 0, 32'h20, 0);
    tick(); idle();
    chk("aux_sh_cpu_lw", cpu_rdata, 32'h00001234);
    drive(0, 0, SZ_WORD, 0, 32'h20, 0);
    drive(1, 0, SZ_WORD, 0, 32'h20, 0);
    #1;
    chk("both_req_cpu_wins", {30'd0, aux_gnt, cpu_gnt}, 32'd1);
    tick(); idle();
    tick();

    // Starvation: aux forced through after SM waits, every SM+1 cycles.
    starve_run(40, g1, g2, both);
    chk("starve_first", g1, SM + 1);
    chk("starve_period", g2 - g1, SM + 1);
    chk("starve_no_double", both, 0);
    tick();

    // Reset one cycle after a granted load, with aux partly starved.
    drive(0, 0, SZ_WORD, 0, 32'h10, 0);
    drive(1, 0, SZ_WORD, 0, 32'h14, 0);
    repeat (5) tick();
    rst = 1;
    #1;
    chk("midrst_rvalid", {31'd0, cpu_rvalid}, 32'd0);
    chk("midrst_dm_ena", {31'd0, dm_ena}, 32'd0);
    tick();
    rst = 0;
    idle();
    #1;
    chk("midrst_rdata", cpu_rdata, 32'd0);
    chk("midrst_rvalid_after", {30'd0, aux_rvalid, cpu_rvalid}, 32'd0);
    starve_run(40, g1, g2, both);
    chk("midrst_cnt_cleared", g1, SM + 1);
    tick();

    // Misaligned word load at 0x02.
    drive(0, 1, SZ_WORD, 0, 32'h00, 32'h04030201);
    tick(); idle();
    drive(0, 1, SZ_WORD, 0, 32'h04, 32'h08070605);
    tick(); idle();
    rd_before = cpu_rdata;
    drive(0, 0, SZ_WORD, 0, 32'h02, 0);
    #1;
    chk("mis_gnt", {31'd0, cpu_gnt}, 32'd1);
`ifdef MISALIGN_TRAP_EN
    chk("mis_dm_ena", {31'd0, dm_ena}, 32'd0);
    tick(); idle();
    chk("mis_err", {31'd0, cpu_err}, 32'd1);
    chk("mis_rvalid", {31'd0, cpu_rvalid}, 32'd0);
    chk("mis_rdata_kept", cpu_rdata, rd_before);
`else
    chk("mis_dm_ena", {31'd0, dm_ena}, 32'd1);
    tick(); idle();
    chk("mis_err", {31'd0, cpu_err}, 32'd0);
    chk("mis_rvalid", {31'd0, cpu_rvalid}, 32'd1);
    chk("mis_rdata", cpu_rdata, 32'h06050403);
`endif
    tick();

    // Randomized run against the transaction-level model.
    rst = 1; clr = 1;
    tick(); tick();
    rst = 0; clr = 0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    begin
      int          waits;
      logic        eg_cpu, eg_aux, ev_cpu, ev_aux, forced;
      logic [31:0] ed;
      waits = 0;
      for (int cyc = 0; cyc < 600; cyc++) begin
        if (!cpu_req && $urandom_range(0, 9) < 7) begin
          logic [1:0] sz = 2'($urandom_range(0, 3));
          logic [31:0] a = 32'($urandom_range(0, 255));
          if (sz == SZ_HALF) a[0] = 1'b0;
          else if (sz != SZ_BYTE) a[1:0] = 2'b00;
          drive(0, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
        end
        if (!aux_req && $urandom_range(0, 9) < 5) begin
          logic [1:0] sz = 2'($urandom_range(0, 3));
          logic [31:0] a = 32'($urandom_range(0, 255));
          if (sz == SZ_HALF) a[0] = 1'b0;
          else if (sz != SZ_BYTE) a[1:0] = 2'b00;
          drive(1, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
        end
        forced = (waits >= SM);
        eg_cpu = forced ? 1'b0 : cpu_req;
        eg_aux = forced ? aux_req : (aux_req & ~cpu_req);
        waits  = (aux_req && !eg_aux) ? waits + 1 : 0;
        ev_cpu = 0; ev_aux = 0; ed = 0;
        if (eg_cpu) begin
          if (cpu_we) begin
            for (int k = 0; k < 4; k++)
              if (size_byteena(cpu_size)[k]) ref_mem[8'(cpu_addr[7:0] + 8'(k))] = cpu_wdata[8*k +: 8];
          end else begin
            ev_cpu = 1; ed = ref_load(cpu_addr, cpu_size, cpu_sext);
          end
        end else if (eg_aux) begin
          if (aux_we) begin
            for (int k = 0; k < 4; k++)
              if (size_byteena(aux_size)[k]) ref_mem[8'(aux_addr[7:0] + 8'(k))] = aux_wdata[8*k +: 8];
          end else begin
            ev_aux = 1; ed = ref_load(aux_addr, aux_size, aux_sext);
          end
        end
        #1;
        chk("rnd_gnt", {30'd0, aux_gnt, cpu_gnt}, {30'd0, eg_aux, eg_cpu});
        tick();
        if (eg_cpu) cpu_req = 0;
        if (eg_aux) aux_req = 0;
        chk("rnd_rvalid", {30'd0, aux_rvalid, cpu_rvalid}, {30'd0, ev_aux, ev_cpu});
        if (ev_cpu || ev_aux) chk("rnd_rdata", ev_aux ? aux_rdata : cpu_rdata, ed);
      end
    end

    idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
